sr595_frame_driver: RTL and testbench
=====================================

// Module: sr595_frame_driver
// PURPOSE
//   Serialises one WIDTH-bit display frame into a chain of 74HC595 shift registers.
//   Outputs: serial clock, serial data and a storage-register latch.
//   Sits downstream of the seven-segment encoder and time/date shift mux; consumes
//   their WIDTH-bit word on a one-cycle start pulse issued once per displayed second.
//   Drives the three display pins of io_out.
// PARAMETERS
//   WIDTH    84  frame length in bits (7 segments x 12 digits)
//   CLK_DIV  1   clk_i cycles per sclk half-period (>=1)
//   PWM_BITS 4   width of brightness duty word (SR595_OE_PWM_EN only)
// PORTS
//   clk_i    in   1         system clock; the only clock
//   rst_i    in   1         reset, asynchronous, active-high
//   start_i  in   1         request to transmit data_i; sampled every cycle
//   data_i   in   WIDTH     frame; bit WIDTH-1 shifted first
//   busy_o   out  1         high while a frame is in SHIFT or LATCH
//   done_o   out  1         one-cycle pulse after latch_o falls
//   sclk_o   out  1         595 SRCLK
//   data_o   out  1         595 SER
//   latch_o  out  1         595 RCLK
//   duty_i   in   PWM_BITS  brightness (SR595_OE_PWM_EN only)
//   oe_n_o   out  1         595 /OE (SR595_OE_PWM_EN only)
// BEHAVIOUR
//   Reset: all outputs 0; oe_n_o 1; state IDLE; pending flag and shadow cleared.
//     Reset acts mid-frame: the chain keeps partial data, and no latch is issued.
//   FSM states: IDLE, SHIFT, LATCH.
//   IDLE: on start_i=1 (or pending=1), capture data_i (or the pending buffer) into
//     the shift shadow and go to SHIFT next cycle. Latency: start at edge N, first
//     data_o valid at N+1.
//   SHIFT: for each bit, MSB first:
//     data_o = shadow[WIDTH-1].
//     sclk_o is 0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
//     The shadow shifts left on the sclk falling transition.
//     Bit counter runs 0..WIDTH-1; after the last high phase go to LATCH.
//   LATCH: sclk_o=0 and latch_o=1 for CLK_DIV cycles, then go to IDLE with
//     done_o=1 for one cycle.
//   Frame length: 2*WIDTH*CLK_DIV + CLK_DIV cycles of busy_o.
//   data_o is 0 in IDLE and LATCH.
//   start_i while busy: set pending and copy data_i into the pending buffer.
//     If pending is already set, the latest data wins.
//     Pending is served in the done_o cycle, so the next first bit appears one cycle
//     after done_o.
//   start_i in the done_o cycle counts as an IDLE start, and takes priority over
//     pending data.
//   start_i held high: frames run back-to-back, each separated by the single done
//     cycle.
// CONFIGURATION
//   SR595_OE_PWM_EN defined:
//     Adds duty_i and oe_n_o, plus a free-running PWM_BITS counter that resets to 0.
//     oe_n_o = !(cnt < duty_i). duty 0 means always blanked; duty 2^PWM_BITS-1
//     means lit for all but one count.
//     duty_i is sampled only at cnt wrap-around, to avoid glitches.
//   SR595_OE_PWM_EN undefined: duty_i and oe_n_o are absent; the 595 /OE is tied
//     low externally. Serial timing is identical in both builds.
// TESTING (WIDTH=8, CLK_DIV=1 unless stated)
//   Single frame: start_i=1 at cycle 0, data_i=8'hA5.
//     -> data_o = 1,0,1,0,0,1,0,1 at sclk rises (cycles 2,4,...,16).
//     -> latch_o=1 at cycle 17; done_o=1 at cycle 18; busy_o=1 on cycles 1-17.
//   Queued frame: 8'hA5 at cycle 0; 8'h3C at cycle 5; 8'hFF at cycle 9.
//     -> After done at cycle 18, the second frame starts at cycle 19 and shifts 8'hFF.
//     -> No third frame is sent.
//   Divider: CLK_DIV=3, data 8'h80.
//     -> sclk high/low 3 cycles each; data_o=1 only in bit 0 window.
//     -> latch_o on cycles 49-51; done_o at 52.
//   Reset mid-frame: rst_i asserted at cycle 7.
//     -> All outputs 0 asynchronously; no latch_o or done_o.
//     -> A new start after release runs a clean full frame.
//   PWM (SR595_OE_PWM_EN): duty 0, 4, 15.
//     -> oe_n_o low for 0, 4 and 15 of every 16 cycles respectively.
//     -> A duty change mid-period takes effect only at the next wrap.

Source files
------------

// File: rtl/sr595_frame_driver_if.sv
// rtl/sr595_frame_driver_if.sv - frame request/status handshake between the display mux and the 595 driver
interface sr595_frame_driver_if #(
  parameter int WIDTH = 84
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             done;

  modport master (output start, output data, input busy, input done);
  modport slave  (input start, input data, output busy, output done);
endinterface

// File: rtl/sr595_frame_driver.sv
// rtl/sr595_frame_driver.sv - serialises one WIDTH-bit frame into a 74HC595 chain (SRCLK/SER/RCLK)
// Optional /OE brightness PWM enabled by defining SR595_OE_PWM_EN.
module sr595_frame_driver #(
  parameter int WIDTH    = 84,
  parameter int CLK_DIV  = 1
`ifdef SR595_OE_PWM_EN
  ,
  parameter int PWM_BITS = 4
`endif
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sr595_frame_driver_if.slave frm,
  output logic                sclk_o,
  output logic                data_o,
  output logic                latch_o
`ifdef SR595_OE_PWM_EN
  ,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                oe_n_o
`endif
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   shadow_q;
  logic [WIDTH-1:0]   pend_buf_q;
  logic               pending_q;
  logic [DIV_W-1:0]   div_q;
  logic [BIT_W-1:0]   bit_q;
  logic               sclk_q;
  logic               data_q;
  logic               latch_q;
  logic               busy_q;
  logic               done_q;
  logic               div_end;

  assign div_end = (div_q == DIV_W'(CLK_DIV - 1));

  // data_q carries the bit on the wire; shadow_q holds the bits still to go, left-aligned.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      pend_buf_q <= '0;
      pending_q  <= 1'b0;
      div_q      <= '0;
      bit_q      <= '0;
      sclk_q     <= 1'b0;
      data_q     <= 1'b0;
      latch_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frm.start || pending_q) begin
            data_q    <= frm.start ? frm.data[WIDTH-1] : pend_buf_q[WIDTH-1];
            shadow_q  <= frm.start ? (frm.data << 1) : (pend_buf_q << 1);
            pending_q <= 1'b0;
            state_q   <= SHIFT;
            busy_q    <= 1'b1;
            div_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
          end
        end
        SHIFT: begin
          if (div_end) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == BIT_W'(WIDTH - 1)) begin
                state_q <= LATCH;
                latch_q <= 1'b1;
                data_q  <= 1'b0;
              end else begin
                data_q   <= shadow_q[WIDTH-1];
                shadow_q <= shadow_q << 1;
                bit_q    <= bit_q + BIT_W'(1);
              end
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        LATCH: begin
          if (div_end) begin
            div_q   <= '0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
      // A request arriving mid-frame is parked; the newest one overwrites older ones.
      if (busy_q && frm.start) begin
        pending_q  <= 1'b1;
        pend_buf_q <= frm.data;
      end
    end
  end

  assign sclk_o   = sclk_q;
  assign data_o   = data_q;
  assign latch_o  = latch_q;
  assign frm.busy = busy_q;
  assign frm.done = done_q;

`ifdef SR595_OE_PWM_EN
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;

  // Duty only changes at wrap so a period never mixes two brightness levels.
  assign cnt_d  = cnt_q + PWM_BITS'(1);
  assign duty_d = (&cnt_q) ? duty_i : duty_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
    end
  end

  assign oe_n_o = !(cnt_q < duty_q);
`endif

endmodule

// File: tb/tb_sr595_frame_driver.sv
// tb/tb_sr595_frame_driver.sv - table-driven check of sr595_frame_driver (CLK_DIV 1 and 3 instances)
module tb_sr595_frame_driver;
  localparam int W = 8;

  typedef struct {
    logic       start;
    logic [7:0] data;
    logic [4:0] exp;   // {busy, done, sclk, sdata, latch}
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr595_frame_driver_if #(.WIDTH(W)) f1 ();
  sr595_frame_driver_if #(.WIDTH(W)) f3 ();
  logic sclk1, sdat1, latch1, sclk3, sdat3, latch3;
`ifdef SR595_OE_PWM_EN
  logic [3:0] duty1, duty3;
  logic       oe1, oe3;
`endif

  sr595_frame_driver #(.WIDTH(W), .CLK_DIV(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .frm(f1), .sclk_o(sclk1), .data_o(sdat1), .latch_o(latch1)
`ifdef SR595_OE_PWM_EN
    , .duty_i(duty1), .oe_n_o(oe1)
`endif
  );

  sr595_frame_driver #(.WIDTH(W), .CLK_DIV(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .frm(f3), .sclk_o(sclk3), .data_o(sdat3), .latch_o(latch3)
`ifdef SR595_OE_PWM_EN
    , .duty_i(duty3), .oe_n_o(oe3)
`endif
  );

  int   nvec = 0;
  int   nbad = 0;
  vec_t tbl[$];

  function automatic logic [4:0] frame_exp(int c, int s, logic [7:0] d, int dv);
    int   r = c - s;
    logic b, dn, sc, sd, la;
    b  = (r >= 1) && (r <= 17 * dv);
    sc = (r >= 1) && (r <= 16 * dv) && ((((r - 1) / dv) % 2) == 1);
    sd = ((r >= 1) && (r <= 16 * dv)) ? d[7 - ((r - 1) / (2 * dv))] : 1'b0;
    la = (r > 16 * dv) && (r <= 17 * dv);
    dn = (r == 17 * dv + 1);
    return {b, dn, sc, sd, la};
  endfunction

  task automatic push(input logic st, input logic [7:0] d, input logic [4:0] e);
    vec_t v;
    v.start = st;
    v.data  = d;
    v.exp   = e;
    tbl.push_back(v);
  endtask

  // Called at the start of cycle 0 (1 time unit after a rising edge); row i is cycle i.
  task automatic run_tbl(input int sel, input string name);
    logic [4:0] got;
    for (int i = 0; i < tbl.size(); i++) begin
      if (sel == 1) begin f1.start = tbl[i].start; f1.data = tbl[i].data; end
      else          begin f3.start = tbl[i].start; f3.data = tbl[i].data; end
      @(negedge clk);
      got = (sel == 1) ? {f1.busy, f1.done, sclk1, sdat1, latch1}
                       : {f3.busy, f3.done, sclk3, sdat3, latch3};
      nvec++;
      if (got !== tbl[i].exp) begin
        nbad++;
        $display("FAIL %s cycle %0d: busy/done/sclk/data/latch got %b required %b",
                 name, i, got, tbl[i].exp);
      end
      @(posedge clk); #1;
    end
    f1.start = 1'b0;
    f3.start = 1'b0;
    tbl.delete();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    nvec++;
    if (got !== req) begin
      nbad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  initial begin
    logic [4:0] bad_win;
    rst = 1'b1;
    f1.start = 1'b0; f1.data = '0;
    f3.start = 1'b0; f3.data = '0;
`ifdef SR595_OE_PWM_EN
    duty1 = 4'd0; duty3 = 4'd0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset dut1 outputs", {f1.busy, f1.done, sclk1, sdat1, latch1}, 0);
    check("reset dut3 outputs", {f3.busy, f3.done, sclk3, sdat3, latch3}, 0);
`ifdef SR595_OE_PWM_EN
    check("reset oe_n", oe1, 1);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single frame A5
    for (int c = 0; c <= 20; c++) push(c == 0, 8'hA5, frame_exp(c, 0, 8'hA5, 1));
    run_tbl(1, "single_A5");

    // Queued: 3C overwritten by FF, served at the done cycle; no third frame
    for (int c = 0; c <= 45; c++)
      push(c == 0 || c == 5 || c == 9, (c == 0) ? 8'hA5 : (c == 5) ? 8'h3C : 8'hFF,
           frame_exp(c, 0, 8'hA5, 1) | frame_exp(c, 18, 8'hFF, 1));
    run_tbl(1, "queued");

    // Start in the done cycle beats pending data, and pending is dropped
    for (int c = 0; c <= 40; c++)
      push(c == 0 || c == 5 || c == 18, (c == 0) ? 8'hA5 : (c == 5) ? 8'h3C : 8'hC3,
           frame_exp(c, 0, 8'hA5, 1) | frame_exp(c, 18, 8'hC3, 1));
    run_tbl(1, "done_cycle_start");

    // start held high: back-to-back frames, one done cycle apart
    for (int c = 0; c <= 75; c++)
      push(c <= 53, (c < 50) ? 8'h5A : 8'h96,
           frame_exp(c, 0, 8'h5A, 1) | frame_exp(c, 18, 8'h5A, 1) |
           frame_exp(c, 36, 8'h5A, 1) | frame_exp(c, 54, 8'h96, 1));
    run_tbl(1, "held_start");

    // Divider CLK_DIV=3 with 80
    for (int c = 0; c <= 55; c++) push(c == 0, 8'h80, frame_exp(c, 0, 8'h80, 3));
    run_tbl(3, "div3_80");

    // Reset in the middle of a frame
    f1.start = 1'b1; f1.data = 8'hA5;
    @(posedge clk); #1;
    f1.start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async reset mid-frame", {f1.busy, f1.done, sclk1, sdat1, latch1}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bad_win = '0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      bad_win = bad_win | {f1.busy, f1.done, sclk1, sdat1, latch1};
    end
    check("no latch/done after reset", bad_win, 0);
    @(posedge clk); #1;
    for (int c = 0; c <= 20; c++) push(c == 0, 8'h3C, frame_exp(c, 0, 8'h3C, 1));
    run_tbl(1, "after_reset_3C");

`ifdef SR595_OE_PWM_EN
    begin
      int   lows;
      logic prev, found;
      for (int t = 0; t < 3; t++) begin
        duty1 = (t == 0) ? 4'd0 : (t == 1) ? 4'd4 : 4'd15;
        repeat (40) @(posedge clk);
        lows = 0;
        for (int k = 0; k < 16; k++) begin @(negedge clk); if (oe1 == 1'b0) lows++; end
        check("pwm lit cycles", lows, (t == 0) ? 0 : (t == 1) ? 4 : 15);
      end
      duty1 = 4'd4;
      repeat (40) @(posedge clk);
      @(negedge clk);
      prev = oe1;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        @(negedge clk);
        if (prev == 1'b0 && oe1 == 1'b1) found = 1'b1;
        prev = oe1;
      end
      check("pwm edge found", found, 1);
      duty1 = 4'd15;
      lows = 0;
      for (int k = 0; k < 11; k++) begin @(negedge clk); if (oe1 == 1'b0) lows++; end
      check("pwm duty held until wrap", lows, 0);
      lows = 0;
      for (int k = 0; k < 16; k++) begin @(negedge clk); if (oe1 == 1'b0) lows++; end
      check("pwm new duty after wrap", lows, 15);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
